// File: rtl/icache_refill_ctrl.sv
// Instruction cache line refill: miss detect, burst read, line write, fence invalidate.
// Optional miss counter output o_miss_count enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
  parameter int BLOCK_WIDTH = 512,
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
  input  logic                   i_fence_i,
  input  logic                   i_hit,
  output logic [ADDR_WIDTH-1:0]  o_cache_addr,
  output logic                   o_cache_we,
  output logic [BLOCK_WIDTH-1:0] o_cache_block,
  output logic                   o_cache_inval,
  output logic                   o_stall,
  output logic                   o_fetch_err,
  output logic                   o_mem_arvalid,
  output logic [ADDR_WIDTH-1:0]  o_mem_araddr,
  input  logic                   i_mem_arready,
  input  logic                   i_mem_rvalid,
  input  logic [WORD_SIZE-1:0]   i_mem_rdata,
  input  logic                   i_mem_rerr
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]            o_miss_count
`endif
);

  localparam int BEATS    = BLOCK_WIDTH / WORD_SIZE;
  localparam int OFFSET_W = $clog2(BLOCK_WIDTH / 8);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    WRITE,
    ERR
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       beat_cnt;
  logic [ADDR_WIDTH-1:0]  line_addr;
  logic [BLOCK_WIDTH-1:0] line_buf;
  logic                   fence_pend;

  logic fence_service;
  logic miss_take;
  logic beat_ok;

  assign fence_service = (state == IDLE) && fence_pend;
  assign miss_take     = (state == IDLE) && !fence_pend
                       && i_fetch_req && !i_hit;
  assign beat_ok       = (state == FILL) && i_mem_rvalid
                       && !i_mem_rerr;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (miss_take) state_nxt = REQ;
      REQ:   if (i_mem_arready) state_nxt = FILL;
      FILL: begin
        if (i_mem_rvalid) begin
          if (i_mem_rerr)
            state_nxt = ERR;
          else if (beat_cnt == LAST)
            state_nxt = WRITE;
        end
      end
      WRITE: state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cache_addr  = line_addr;
    o_stall       = 1'b1;
    o_cache_we    = 1'b0;
    o_cache_inval = 1'b0;
    o_fetch_err   = 1'b0;
    o_mem_arvalid = 1'b0;
    unique case (state)
      IDLE: begin
        o_cache_addr  = i_fetch_addr;
        o_stall       = i_fetch_req & ~i_hit;
        o_cache_inval = fence_pend;
      end
      REQ:   o_mem_arvalid = 1'b1;
      FILL:  o_stall = 1'b1;
      WRITE: o_cache_we = 1'b1;
      ERR:   o_fetch_err = 1'b1;
      default: o_stall = 1'b1;
    endcase
  end

  assign o_cache_block = line_buf;
  assign o_mem_araddr  = line_addr;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      beat_cnt  <= '0;
      line_addr <= '0;
      line_buf  <= '0;
    end else begin
      if (miss_take)
        line_addr <= {i_fetch_addr[ADDR_WIDTH-1:OFFSET_W],
                      {OFFSET_W{1'b0}}};
      if (state == REQ && i_mem_arready)
        beat_cnt <= '0;
      else if (beat_ok)
        beat_cnt <= beat_cnt + 1'b1;
      if (beat_ok)
        line_buf[beat_cnt*WORD_SIZE +: WORD_SIZE] <= i_mem_rdata;
    end
  end

  // A fence arriving in the servicing cycle merges into that invalidate.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fence_pend <= 1'b0;
    end else if (fence_service) begin
      fence_pend <= 1'b0;
    end else if (i_fence_i) begin
      fence_pend <= 1'b1;
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_miss_count <= '0;
    end else if (miss_take) begin
      o_miss_count <= o_miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameters: BLOCK_WIDTH, default 512, cache line width in bits; WORD_SIZE, default 32, memory beat and instruction width; ADDR_WIDTH, default 32, address width.
REQ-002 SHALL derive BEATS = BLOCK_WIDTH/WORD_SIZE (16) and OFFSET_W = $clog2(BLOCK_WIDTH/8) (6).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock, all state updates on rising edge.
- arst  in  1  reset, asynchronous, active-high.
- i_fetch_req  in  1  core requests an instruction this cycle.
- i_fetch_addr  in  ADDR_WIDTH  core fetch address.
- i_fence_i  in  1  one-cycle request to invalidate the instruction cache.
- i_hit  in  1  cache hit for o_cache_addr.
- o_cache_addr  out  ADDR_WIDTH  address driven to the cache.
- o_cache_we  out  1  cache line write enable.
- o_cache_block  out  BLOCK_WIDTH  assembled line to the cache.
- o_cache_inval  out  1  cache invalidate pulse.
- o_stall  out  1  core fetch shall stall.
- o_fetch_err  out  1  one-cycle bus error indication.
- o_mem_arvalid  out  1  read burst request valid.
- o_mem_araddr  out  ADDR_WIDTH  line-aligned burst address.
- i_mem_arready  in  1  memory accepts request.
- i_mem_rvalid  in  1  read beat valid.
- i_mem_rdata  in  WORD_SIZE  read beat data.
- i_mem_rerr  in  1  beat carries a bus error, qualified by i_mem_rvalid.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, FILL, WRITE, ERR.
REQ-005 IDLE: o_cache_addr SHALL equal i_fetch_addr; o_stall SHALL equal i_fetch_req & ~i_hit, combinationally.
REQ-006 IDLE, fence pending flag set: SHALL assert o_cache_inval for one cycle, clear the flag, stay IDLE; a miss in that cycle waits.
REQ-007 IDLE, no pending fence, i_fetch_req & ~i_hit: SHALL latch {i_fetch_addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'0} as line address and go to REQ.
REQ-008 REQ: o_mem_arvalid=1 and o_mem_araddr=line address, held stable until i_mem_arready; on arready SHALL clear beat counter and go to FILL.
REQ-009 FILL: each i_mem_rvalid beat with i_mem_rerr=0 SHALL store i_mem_rdata into word slot beat_cnt (slot 0 = bits WORD_SIZE-1:0) and increment beat_cnt.
REQ-010 FILL: the beat with beat_cnt==BEATS-1 SHALL go to WRITE; no rvalid means hold.
REQ-011 FILL: rvalid & rerr on any beat SHALL go to ERR; buffer contents SHALL not be written to the cache.
REQ-012 WRITE: o_cache_we=1 for exactly one cycle, o_cache_addr=line address, o_cache_block=buffer; then IDLE.
REQ-013 ERR: o_fetch_err=1 for exactly one cycle, o_cache_we=0; then IDLE.
REQ-014 In REQ, FILL, WRITE, ERR: o_stall=1; o_cache_addr=line address.
REQ-015 i_fence_i in any cycle not serviced per REQ-006 SHALL set the fence pending flag; the flag persists until serviced; repeated fences SHALL merge into one invalidate.
REQ-016 i_fence_i in IDLE with flag clear SHALL set the flag, so o_cache_inval pulses the following cycle.
REQ-017 Miss-to-hit latency with zero-wait memory: 1 (IDLE) + 1 (REQ) + BEATS (FILL) + 1 (WRITE) cycles; the fetch hits on the cycle after WRITE.
REQ-018 o_mem_arvalid, o_cache_we, o_cache_inval and o_fetch_err SHALL be 0 outside the states named above.

Reset
REQ-019 arst SHALL force, asynchronously, state=IDLE, beat_cnt=0, line address=0, buffer=0 and fence flag=0.
REQ-020 During reset, o_cache_we, o_cache_inval, o_fetch_err and o_mem_arvalid SHALL be 0.
REQ-021 arst during REQ or FILL SHALL abandon the burst with no cache write; beats arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-022 Macro ICACHE_REFILL_PERF_EN defined: SHALL add output o_miss_count, 32 bits, reset 0, incremented on each IDLE->REQ transition, wrapping 0xFFFFFFFF->0.
REQ-023 Macro ICACHE_REFILL_PERF_EN undefined: o_miss_count SHALL not exist; all other behaviour is identical.

Verification
REQ-024 Miss at 0x0000_0148, arready same cycle, 16 beats 0x1000+n back-to-back -> araddr=0x0000_0140; o_cache_we pulses once at cycle 18; o_cache_block word n = 0x1000+n; o_stall drops on the cycle after.
REQ-025 arready delayed 5 cycles, rvalid gapped every other cycle -> araddr stable while arvalid; exactly 16 stored beats; single o_cache_we pulse.
REQ-026 rerr on beat 7 -> o_fetch_err pulses once; o_cache_we never asserts; state returns to IDLE; the next miss restarts at beat 0.
REQ-027 i_fence_i pulsed twice during FILL -> exactly one o_cache_inval, one cycle after the WRITE cycle; a waiting miss issues its REQ the cycle after that.
REQ-028 arst asserted on beat 9 -> outputs go to 0 immediately; stray rvalid after release gives no o_cache_we; with ICACHE_REFILL_PERF_EN defined, o_miss_count reads 0 and then 1 after the next miss.
